// File: rtl/ped_call_pkg.sv
// Shared types and defaults for the pedestrian call unit.
// The optional PED_CALL_LATCH_EN feature lives in ped_call_unit.sv.
package ped_call_pkg;

   localparam int DEBOUNCE_CYCLES_DEF = 4;
   localparam int HOLDOFF_DEF         = 8;
   localparam int CNT_W_DEF           = 8;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ARMED    = 2'd1,
      ST_SERVING  = 2'd2,
      ST_COOLDOWN = 2'd3
   } ped_state_e;

endpackage

// File: rtl/ped_call_if.sv
// Pedestrian call unit bundle: raw button, controller request/walk pair,
// wait reporting and a debug view of the FSM state.
interface ped_call_if
   import ped_call_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
);
   // Request handshake: N is held high from the accepting edge until the
   // first edge that samples P=1; N falls and served pulses on that same edge.
   logic             btn;
   logic             P;
   logic             N;
   logic             wait_lamp;
   logic [CNT_W-1:0] wait_cnt;
   logic             wait_sat;
   logic             served;
   ped_state_e       dbg_state;

   modport master (
      input  btn, P,
      output N, wait_lamp, wait_cnt, wait_sat, served, dbg_state
   );

   modport slave (
      output btn, P,
      input  N, wait_lamp, wait_cnt, wait_sat, served, dbg_state
   );

endinterface

// File: rtl/ped_btn_debounce.sv
// Two-flop synchronizer plus counting debouncer for the crossing button;
// emits a one-cycle press pulse on each accepted 0->1 level change.
module ped_btn_debounce
   import ped_call_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_1;
   logic          btn_s;
   logic          db;
   logic [CW-1:0] mis_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_1  <= 1'b0;
         btn_s   <= 1'b0;
         db      <= 1'b0;
         mis_cnt <= '0;
         press   <= 1'b0;
      end else begin
         sync_1 <= btn;
         btn_s  <= sync_1;
         press  <= 1'b0;
         if (btn_s == db) begin
            mis_cnt <= '0;
         end else if (mis_cnt == CNT_LAST) begin
            // The N-th consecutive disagreeing sample commits the new level.
            db      <= ~db;
            mis_cnt <= '0;
            press   <= ~db;
         end else begin
            mis_cnt <= mis_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ped_call_unit.sv
// Pedestrian call endpoint: debounced button -> request N, retired by walk P,
// post-walk hold-off and wait timing. Option macro: PED_CALL_LATCH_EN.
module ped_call_unit
   import ped_call_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int HOLDOFF         = HOLDOFF_DEF,
   parameter int CNT_W           = CNT_W_DEF
) (
   input  logic      clk,
   input  logic      rst,
   ped_call_if.master bus
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_ARMED    = 2'd1;
   localparam logic [1:0] S_SERVING  = 2'd2;
   localparam logic [1:0] S_COOLDOWN = 2'd3;

   localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [HW-1:0]    HOLD_LOAD = HW'(HOLDOFF - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_NEAR  = CNT_MAX - 1'b1;

   logic             press;
   logic [1:0]       state_q;
   logic [1:0]       state_d;
   logic [HW-1:0]    hold_q;
   logic [CNT_W-1:0] cnt_q;
   logic             sat_q;
   logic             n_q;
   logic             served_q;
   logic             hold_done;
   logic             resume;

   ped_btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .btn   (bus.btn),
      .press (press)
   );

   assign hold_done = (state_q == S_COOLDOWN) && (hold_q == '0);

`ifdef PED_CALL_LATCH_EN
   logic pend_q;

   // A press during the walk or hold-off is remembered and replayed on exit;
   // a press landing on the exit edge itself is not kept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q <= 1'b0;
      end else if (hold_done) begin
         pend_q <= 1'b0;
      end else if (press && (state_q == S_SERVING || state_q == S_COOLDOWN)) begin
         pend_q <= 1'b1;
      end
   end

   assign resume = pend_q;
`else
   assign resume = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (press && !bus.P) state_d = S_ARMED;
         S_ARMED:    if (bus.P)           state_d = S_SERVING;
         S_SERVING:  if (!bus.P)          state_d = S_COOLDOWN;
         S_COOLDOWN: if (hold_done)       state_d = resume ? S_ARMED : S_IDLE;
         default:                         state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         hold_q   <= '0;
         cnt_q    <= '0;
         sat_q    <= 1'b0;
         n_q      <= 1'b0;
         served_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         n_q      <= (state_d == S_ARMED);
         served_q <= (state_q == S_ARMED) && bus.P;

         if (state_q == S_SERVING && state_d == S_COOLDOWN) begin
            hold_q <= HOLD_LOAD;
         end else if (state_q == S_COOLDOWN && hold_q != '0) begin
            hold_q <= hold_q - 1'b1;
         end

         // Wait timing restarts on every ARMED entry and freezes elsewhere.
         if (state_q != S_ARMED && state_d == S_ARMED) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
         end else if (state_q == S_ARMED && state_d == S_ARMED && cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_NEAR) sat_q <= 1'b1;
         end
      end
   end

   assign bus.N         = n_q;
   assign bus.wait_lamp = n_q;
   assign bus.wait_cnt  = cnt_q;
   assign bus.wait_sat  = sat_q;
   assign bus.served    = served_q;
   assign bus.dbg_state = ped_state_e'(state_q);

endmodule

// File: tb/tb_ped_call_unit.sv
// Bench for ped_call_unit: directed scenarios plus random button/walk traffic
// checked against a behavioural model; an 8-bit and a 4-bit counter instance.
module tb_ped_call_unit;
   import ped_call_pkg::*;

   localparam int DEB  = 4;
   localparam int HOLD = 8;
`ifdef PED_CALL_LATCH_EN
   localparam bit LATCH_EN = 1'b1;
`else
   localparam bit LATCH_EN = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn = 1'b0;
   logic p   = 1'b0;

   always #5 clk = ~clk;

   ped_call_if #(.CNT_W(8)) bus8 ();
   ped_call_if #(.CNT_W(4)) bus4 ();

   assign bus8.btn = btn;
   assign bus8.P   = p;
   assign bus4.btn = btn;
   assign bus4.P   = p;

   ped_call_unit #(.DEBOUNCE_CYCLES(DEB), .HOLDOFF(HOLD), .CNT_W(8)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
   );

   ped_call_unit #(.DEBOUNCE_CYCLES(DEB), .HOLDOFF(HOLD), .CNT_W(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   // ---------------- scoreboard / counters ----------------
   int n_vec = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit btn_hist[$];    // last two raw button samples, newest first
   bit m_db, m_press, m_req, m_walk, m_pend, m_served, m_sat8, m_sat4;
   int m_run, m_hold, m_cnt8, m_cnt4;

   task automatic model_reset();
      btn_hist = {1'b0, 1'b0};
      m_db = 0; m_press = 0; m_req = 0; m_walk = 0; m_pend = 0; m_served = 0;
      m_sat8 = 0; m_sat4 = 0; m_run = 0; m_hold = -1; m_cnt8 = 0; m_cnt4 = 0;
      exp_q.delete();
   endtask

   task automatic start_wait();
      m_req = 1; m_cnt8 = 0; m_cnt4 = 0; m_sat8 = 0; m_sat4 = 0;
   endtask

   task automatic model_edge(input bit b, input bit pv);
      bit bs;
      bit press_now;
      bs = btn_hist[1];
      btn_hist.push_front(b);
      void'(btn_hist.pop_back());
      press_now = 0;
      if (bs != m_db) begin
         m_run++;
         if (m_run == DEB) begin
            m_db = !m_db;
            m_run = 0;
            press_now = m_db;
         end
      end else begin
         m_run = 0;
      end

      m_served = 0;
      if (m_req) begin
         if (pv) begin
            m_req = 0; m_walk = 1; m_served = 1;
            exp_q.push_back(8'(m_cnt8));
         end else begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt8 == 255) m_sat8 = 1;
            if (m_cnt4 < 15) m_cnt4++;
            if (m_cnt4 == 15) m_sat4 = 1;
         end
      end else if (m_walk) begin
         if (LATCH_EN && m_press) m_pend = 1;
         if (!pv) begin
            m_walk = 0;
            m_hold = HOLD - 1;
         end
      end else if (m_hold >= 0) begin
         if (m_hold == 0) begin
            m_hold = -1;
            if (m_pend) begin
               m_pend = 0;
               start_wait();
            end
         end else begin
            m_hold--;
            if (LATCH_EN && m_press) m_pend = 1;
         end
      end else if (m_press && !pv) begin
         start_wait();
      end
      m_press = press_now;
   endtask

   task automatic compare_all();
      check_val("n", bus8.N, m_req);
      check_val("wait_lamp", bus8.wait_lamp, m_req);
      check_val("served", bus8.served, m_served);
      check_val("wait_cnt8", bus8.wait_cnt, m_cnt8);
      check_val("wait_sat8", bus8.wait_sat, m_sat8);
      check_val("wait_cnt4", bus4.wait_cnt, m_cnt4);
      check_val("wait_sat4", bus4.wait_sat, m_sat4);
      if (bus8.served === 1'b1) begin
         if (exp_q.size() == 0) check_val("served_unexpected", 1, 0);
         else check_val("served_wait_cnt", bus8.wait_cnt, exp_q.pop_front());
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input bit b, input bit pv);
      btn = b;
      p   = pv;
      @(posedge clk);
      model_edge(b, pv);
      @(negedge clk);
      compare_all();
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, "_n"}, bus8.N, 0);
      check_val({tag, "_lamp"}, bus8.wait_lamp, 0);
      check_val({tag, "_cnt"}, bus8.wait_cnt, 0);
      check_val({tag, "_sat"}, bus8.wait_sat, 0);
      check_val({tag, "_served"}, bus8.served, 0);
      check_val({tag, "_cnt4"}, bus4.wait_cnt, 0);
   endtask

   task automatic async_reset();
      #2 rst = 1'b1;
      #1 check_zero("rst_async");
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int b_left;
      int p_left;
      bit rb;
      bit rp;
      model_reset();
      #3 check_zero("rst_init");
      @(negedge clk);
      rst = 1'b0;

      // press latency from the first sampling edge
      repeat (6) step(1, 0);
      check_val("n_before_edge6", bus8.N, 0);
      step(1, 0);
      check_val("n_at_edge6", bus8.N, 1);

      // service after ten counted edges
      repeat (10) step(0, 0);
      step(0, 1);
      check_val("serve_served", bus8.served, 1);
      check_val("serve_n", bus8.N, 0);
      check_val("serve_cnt", bus8.wait_cnt, 10);
      step(0, 1);
      check_val("serve_pulse_end", bus8.served, 0);
      check_val("serve_cnt_held", bus8.wait_cnt, 10);

      // press inside the hold-off
      step(0, 0);
      repeat (5) step(1, 0);
      repeat (2) step(0, 0);
      check_val("holdoff_n_early", bus8.N, 0);
      step(0, 0);
      check_val("holdoff_n_exit", bus8.N, LATCH_EN);
      check_val("holdoff_cnt", bus8.wait_cnt, LATCH_EN ? 0 : 10);
      repeat (20) step(0, 0);
      step(0, 1);
      step(0, 0);
      repeat (12) step(0, 0);

      // short glitch is rejected
      repeat (3) step(1, 0);
      repeat (20) step(0, 0);
      check_val("glitch_n", bus8.N, 0);

      // press during a walk already in progress
      repeat (10) step(1, 1);
      repeat (8) step(0, 1);
      repeat (20) step(0, 0);
      check_val("walk_busy_n", bus8.N, 0);

      // saturation on both counter widths
      repeat (7) step(1, 0);
      check_val("sat_armed", bus8.N, 1);
      repeat (20) step(0, 0);
      check_val("sat4_cnt", bus4.wait_cnt, 15);
      check_val("sat4_flag", bus4.wait_sat, 1);
      check_val("sat8_not_yet", bus8.wait_sat, 0);
      repeat (240) step(0, 0);
      check_val("sat8_cnt", bus8.wait_cnt, 255);
      check_val("sat8_flag", bus8.wait_sat, 1);

      // reset mid-request with the button held through it
      repeat (6) step(1, 0);
      async_reset();
      repeat (6) step(1, 0);
      check_val("rst_rearm_early", bus8.N, 0);
      step(1, 0);
      check_val("rst_rearm_edge6", bus8.N, 1);
      repeat (4) step(0, 0);
      step(0, 1);
      repeat (14) step(0, 0);

      // random button / walk traffic
      b_left = 0;
      p_left = 0;
      rb = 0;
      rp = 0;
      for (int i = 0; i < 2500; i++) begin
         if (b_left == 0) begin
            rb = 1'($urandom_range(0, 1));
            b_left = $urandom_range(1, 12);
         end
         if (p_left == 0) begin
            rp = ($urandom_range(0, 3) == 0);
            p_left = $urandom_range(1, 25);
         end
         b_left--;
         p_left--;
         step(rb, rp);
      end

      check_val("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ped_call_unit.md
# ped_call_unit

Pedestrian-side endpoint of the traffic-light controller interface. It conditions the raw crossing pushbutton and drives the controller's request input `N`. It watches the controller's walk light `P` to retire the request, runs a post-walk hold-off, and reports how long the pedestrian waited. It shares `clk` with the controller and sits between the board button and the controller's `N` port.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronized samples needed to accept a button level change; must be ≥1.
- `HOLDOFF`, 8: cycles after `P` falls during which presses are not accepted; must be ≥1.
- `CNT_W`, 8: width of the wait counter.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `btn`  in  1  raw pushbutton, asynchronous to `clk`, active-high.
- `P`  in  1  controller walk light, synchronous to `clk`.
- `N`  out  1  registered pedestrian request to the controller.
- `wait_lamp`  out  1  "WAIT" indicator; equals `N`.
- `wait_cnt`  out  CNT_W  cycles spent in ARMED for the current or last request.
- `wait_sat`  out  1  `wait_cnt` saturated during the current or last request.
- `served`  out  1  one-cycle pulse when the request is retired by `P`.

## Operation
- Button path:
  - Two-flop synchronizer produces `btn_s`.
  - The debouncer holds a level `db`, reset value 0, and a mismatch counter.
  - The counter clears whenever `btn_s == db`.
  - On the `DEBOUNCE_CYCLES`-th consecutive mismatched sample, `db` flips. If it flips 0→1, a registered `press` pulse is raised.
- FSM states: IDLE, ARMED, SERVING, COOLDOWN. Reset state is IDLE.
- IDLE:
  - `press` with `P`=0: go to ARMED and clear `wait_cnt` and `wait_sat`.
  - `press` with `P`=1: ignored, because a walk is already in progress.
- ARMED:
  - `N`=1.
  - `wait_cnt` increments each cycle, saturating at 2^CNT_W−1. `wait_sat` is set when the counter saturates.
  - `P` sampled 1: go to SERVING and pulse `served`. `wait_cnt` does not increment on that edge.
- SERVING: `N`=0. `P` sampled 0: go to COOLDOWN and load the hold-off counter with `HOLDOFF`−1.
- COOLDOWN: the hold-off counter decrements each cycle. When it reaches 0, go to IDLE on the next edge.
- Presses in SERVING or COOLDOWN are discarded (see Configuration).
- `wait_cnt` and `wait_sat` hold their values outside ARMED until the next ARMED entry.

## Timing
- Reset values: `N`=0, `wait_lamp`=0, `wait_cnt`=0, `wait_sat`=0, `served`=0. The debounce level and all counters are also 0.
- `rst` forces these values immediately, without waiting for a clock edge.
- A button already held through reset is accepted as a new press after reset releases.
- Press latency: let edge 0 be the first edge that samples `btn`=1.
  - `btn_s`=1 at edge 1.
  - `db` and `press` are set at edge `DEBOUNCE_CYCLES`+1.
  - `N`=1 at edge `DEBOUNCE_CYCLES`+2, which is edge 6 for the default.
- A pulse on `btn_s` shorter than `DEBOUNCE_CYCLES` samples is not accepted.
- `N` falls, and `served` rises, at the first edge that samples `P`=1 in ARMED. `served` lasts exactly one cycle.
- `press` arriving at the same edge the FSM leaves COOLDOWN is discarded.
- Every output is registered; there are no combinational paths from input to output.

## Configuration
- Macro: `PED_CALL_LATCH_EN`.
- Defined:
  - A press accepted in SERVING or COOLDOWN sets a one-bit pending flag.
  - On leaving COOLDOWN with the flag set, the FSM goes directly to ARMED, clears the flag, and clears `wait_cnt`.
  - `N` rises one edge after hold-off expiry.
- Undefined: such presses are dropped and the flag logic is absent.

## Structure
- Package `ped_call_pkg` holds:
  - the state enum (IDLE/ARMED/SERVING/COOLDOWN);
  - the default constants for `DEBOUNCE_CYCLES` and `HOLDOFF`.
- Sub-module `ped_btn_debounce` contains the synchronizer, debounce counter, `db` level and `press` pulse.
- The top level contains the FSM, hold-off counter, wait counter and pending flag.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `HOLDOFF`=8, `CNT_W`=8 unless stated.
- Reset: pulse `rst` mid-cycle → all outputs are 0 immediately, before the next edge.
- Debounce:
  - `btn` held high from edge 0 → `N`=1 at edge 6.
  - A 3-cycle `btn` glitch → `N` stays 0 for 20 cycles.
- Service:
  - While ARMED, raise `P` at the 10th edge after entry.
  - Required: `wait_cnt`=10 and held, `served`=1 for one cycle, `N`=0 from that edge.
- Hold-off:
  - Drop `P`, then press with `btn` held 5 cycles inside COOLDOWN.
  - Without the macro: `N` stays 0 indefinitely.
  - With the macro: `N`=1 one edge after the 8-cycle hold-off expires, and `wait_cnt` restarts at 0.
- Saturation: with `CNT_W`=4, keep ARMED for 20 cycles → `wait_cnt`=15, `wait_sat`=1.
- Reset mid-request:
  - Assert `rst` in ARMED with `btn` still held → `N`=0 at once.
  - After release, `N`=1 at edge 6 counted from the first post-reset edge.
- Walk in progress: press while `P`=1 in IDLE → `N` never asserts.
